// File: rtl/sys_cmd_master.sv
// Host-side command initiator: frames one register/ALU command onto a UART
// byte stream and waits for the single response byte (reads and ALU only).
module sys_cmd_master #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VLD,
    output logic       CMD_RDY,
    input  logic [1:0] CMD_TYPE,
    input  logic [3:0] CMD_ADDR,
    input  logic [7:0] CMD_WDATA,
    input  logic [7:0] CMD_OPA,
    input  logic [7:0] CMD_OPB,
    input  logic [3:0] CMD_FUN,
    output logic [7:0] TX_DATA,
    output logic       TX_VLD,
    input  logic       TX_RDY,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VLD,
    output logic [7:0] RSP_DATA,
    output logic       RSP_VLD,
    output logic       RSP_TIMEOUT,
    output logic       CMD_DONE
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic            rsp_vld_nxt, rsp_to_nxt, done_nxt, capture;

    logic [1:0] typ;
    logic [3:0] addr, fun;
    logic [7:0] wdata, opa, opb;

    function automatic logic [1:0] frame_last(input logic [1:0] t);
        case (t)
            2'b00:   frame_last = 2'd2;
            2'b10:   frame_last = 2'd3;
            default: frame_last = 2'd1;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [1:0] t, input logic [1:0] i,
        input logic [3:0] a, input logic [7:0] wd,
        input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f
    );
        frame_byte = 8'h00;
        case (t)
            2'b00: case (i)
                2'd0:    frame_byte = 8'hAA;
                2'd1:    frame_byte = {4'h0, a};
                default: frame_byte = wd;
            endcase
            2'b01:   frame_byte = (i == 2'd0) ? 8'hBB : {4'h0, a};
            2'b10: case (i)
                2'd0:    frame_byte = 8'hCC;
                2'd1:    frame_byte = oa;
                2'd2:    frame_byte = ob;
                default: frame_byte = {4'h0, f};
            endcase
            default: frame_byte = (i == 2'd0) ? 8'hDD : {4'h0, f};
        endcase
    endfunction

    // Command fields only matter while busy, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (state == IDLE && CMD_VLD) begin
            typ   <= CMD_TYPE;
            addr  <= CMD_ADDR;
            wdata <= CMD_WDATA;
            opa   <= CMD_OPA;
            opb   <= CMD_OPB;
            fun   <= CMD_FUN;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        rsp_vld_nxt = 1'b0;
        rsp_to_nxt  = 1'b0;
        done_nxt    = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (CMD_VLD) begin
                    idx_nxt   = 2'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (TX_RDY) begin
                    if (idx == frame_last(typ)) begin
                        idx_nxt = 2'd0;
                        if (typ == 2'b00) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = WAIT_RSP;
                        end
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            WAIT_RSP: begin
                cnt_nxt = cnt + 1'b1;
                // A response in the final count cycle takes priority over the timeout.
                if (RX_VLD) begin
                    capture     = 1'b1;
                    rsp_vld_nxt = 1'b1;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end else if (cnt == TO_LAST) begin
                    rsp_to_nxt = 1'b1;
                    done_nxt   = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= '0;
            RSP_DATA    <= 8'h00;
            RSP_VLD     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            CMD_DONE    <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            RSP_VLD     <= rsp_vld_nxt;
            RSP_TIMEOUT <= rsp_to_nxt;
            CMD_DONE    <= done_nxt;
            if (capture) RSP_DATA <= RX_DATA;
        end
    end

    // Handshake outputs decode purely from registered state and index.
    assign CMD_RDY = (state == IDLE);
    assign TX_VLD  = (state == SEND);
    assign TX_DATA = TX_VLD ? frame_byte(typ, idx, addr, wdata, opa, opb, fun) : 8'h00;

endmodule

// File: tb/tb_sys_cmd_master.sv
// Scoreboard bench for sys_cmd_master: expected TX bytes and command outcomes
// are queued at issue time and checked by an independent negedge monitor.
module tb_sys_cmd_master;

    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CMD_VLD = 1'b0;
    logic       CMD_RDY;
    logic [1:0] CMD_TYPE = '0;
    logic [3:0] CMD_ADDR = '0;
    logic [7:0] CMD_WDATA = '0;
    logic [7:0] CMD_OPA = '0;
    logic [7:0] CMD_OPB = '0;
    logic [3:0] CMD_FUN = '0;
    logic [7:0] TX_DATA;
    logic       TX_VLD;
    logic       TX_RDY = 1'b0;
    logic [7:0] RX_DATA = '0;
    logic       RX_VLD = 1'b0;
    logic [7:0] RSP_DATA;
    logic       RSP_VLD;
    logic       RSP_TIMEOUT;
    logic       CMD_DONE;

    always #5 CLK = ~CLK;

    sys_cmd_master #(.TIMEOUT(TO), .TO_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_OPA(CMD_OPA),
        .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY),
        .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
        .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT),
        .CMD_DONE(CMD_DONE)
    );

    // flags = {RSP_VLD, RSP_TIMEOUT, CMD_DONE}
    typedef struct packed {
        logic [2:0] flags;
        logic [7:0] data;
    } out_t;

    logic [7:0] tx_q[$];
    out_t       out_q[$];
    logic [7:0] last_rsp = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic scramble_fields();
        CMD_TYPE  = 2'($urandom);
        CMD_ADDR  = 4'($urandom);
        CMD_WDATA = 8'($urandom);
        CMD_OPA   = 8'($urandom);
        CMD_OPB   = 8'($urandom);
        CMD_FUN   = 4'($urandom);
    endtask

    // d: wait-state cycle index (0 = first cycle in the response wait) at which RX_VLD pulses.
    // stall: 0 TX_RDY high, 1 toggling, 2 random.
    task automatic run_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                           input int d, input logic [7:0] rd, input int stall, input bit hold);
        logic [7:0] fr[$];
        out_t o;
        int budget, sent, k, exp_k;
        logic tog, fire;
        budget = 0;
        while (!CMD_RDY && budget < 100) begin
            tick();
            budget++;
        end
        chk("cmd_rdy_before_issue", CMD_RDY, 1);
        fr.delete();
        case (t)
            2'b00: begin fr.push_back(8'hAA); fr.push_back({4'h0, a}); fr.push_back(wd); end
            2'b01: begin fr.push_back(8'hBB); fr.push_back({4'h0, a}); end
            2'b10: begin fr.push_back(8'hCC); fr.push_back(oa); fr.push_back(ob); fr.push_back({4'h0, f}); end
            default: begin fr.push_back(8'hDD); fr.push_back({4'h0, f}); end
        endcase
        foreach (fr[i]) tx_q.push_back(fr[i]);
        if (t == 2'b00) begin
            o.flags = 3'b001; o.data = last_rsp; exp_k = 0;
        end else if (d < TO) begin
            o.flags = 3'b101; o.data = rd; last_rsp = rd; exp_k = d + 1;
        end else begin
            o.flags = 3'b011; o.data = last_rsp; exp_k = TO;
        end
        out_q.push_back(o);

        CMD_TYPE = t; CMD_ADDR = a; CMD_WDATA = wd; CMD_OPA = oa; CMD_OPB = ob; CMD_FUN = f;
        CMD_VLD = 1'b1;
        RX_VLD = 1'b0;
        tick();
        if (!hold) CMD_VLD = 1'b0;

        sent = 0; tog = 1'b1; budget = 0;
        while (sent < fr.size() && budget < 200) begin
            chk("tx_vld_in_send", TX_VLD, 1);
            TX_RDY = (stall == 0) ? 1'b1 : (stall == 1) ? tog : 1'($urandom);
            tog = ~tog;
            RX_VLD = ($urandom_range(0, 3) == 0);
            RX_DATA = 8'($urandom);
            if (hold) scramble_fields();
            fire = TX_VLD && TX_RDY;
            tick();
            if (fire) sent++;
            budget++;
        end

        RX_VLD = 1'b0;
        TX_RDY = 1'($urandom);
        k = 0;
        while (!CMD_DONE && k < TO + 20) begin
            RX_VLD = (t != 2'b00) && (k == d);
            RX_DATA = (k == d) ? rd : 8'($urandom);
            if (hold) scramble_fields();
            tick();
            k++;
        end
        RX_VLD = 1'b0;
        CMD_VLD = 1'b0;
        chk("done_latency", k, exp_k);

        repeat ($urandom_range(0, 2)) begin
            RX_VLD = 1'($urandom);
            RX_DATA = 8'($urandom);
            tick();
        end
        RX_VLD = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            if (TX_VLD) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_byte", {24'h0, TX_DATA}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", TX_DATA, tx_q[0]);
                    if (TX_RDY) void'(tx_q.pop_front());
                end
            end else begin
                chk("tx_data_zero_when_idle", TX_DATA, 0);
            end
            if (CMD_DONE || RSP_VLD || RSP_TIMEOUT) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_outcome", {RSP_VLD, RSP_TIMEOUT, CMD_DONE}, 0);
                end else begin
                    out_t o;
                    o = out_q.pop_front();
                    chk("outcome_flags", {RSP_VLD, RSP_TIMEOUT, CMD_DONE}, o.flags);
                    chk("rsp_data", RSP_DATA, o.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 RST = 1'b0;
        #1;
        chk("rst_cmd_rdy", CMD_RDY, 1);
        chk("rst_tx_vld", TX_VLD, 0);
        chk("rst_tx_data", TX_DATA, 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_pulses", {RSP_VLD, RSP_TIMEOUT, CMD_DONE}, 0);
        repeat (3) tick();
        RST = 1'b1;
        tick();

        run_cmd(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 0, 8'h00, 0, 1'b0);
        run_cmd(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 3, 8'h7E, 0, 1'b0);
        chk("cmd_rdy_after_rsp", CMD_RDY, 1);
        run_cmd(2'b10, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0, 2, 8'h30, 1, 1'b0);
        run_cmd(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 100, 8'h99, 0, 1'b0);
        run_cmd(2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, TO - 1, 8'h5A, 2, 1'b0);
        run_cmd(2'b01, 4'hB, 8'h00, 8'h00, 8'h00, 4'h0, TO, 8'hA5, 0, 1'b0);
        run_cmd(2'b00, 4'h9, 8'hE1, 8'h00, 8'h00, 4'h0, 0, 8'h00, 1, 1'b1);
        run_cmd(2'b10, 4'h0, 8'h00, 8'h44, 8'h55, 4'hF, 4, 8'h66, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    4'($urandom), $urandom_range(0, TO + 2), 8'($urandom),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        // Reset while the third byte of an ALU frame is on the wire.
        CMD_TYPE = 2'b10; CMD_OPA = 8'h11; CMD_OPB = 8'h22; CMD_FUN = 4'h5;
        tx_q.push_back(8'hCC); tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h05);
        TX_RDY = 1'b1;
        CMD_VLD = 1'b1;
        tick();
        CMD_VLD = 1'b0;
        tick();
        tick();
        chk("pre_rst_third_byte", {TX_VLD, TX_DATA}, {1'b1, 8'h22});
        RST = 1'b0;
        #1;
        chk("midframe_rst_tx_vld", TX_VLD, 0);
        chk("midframe_rst_cmd_rdy", CMD_RDY, 1);
        chk("midframe_rst_tx_data", TX_DATA, 0);
        chk("midframe_rst_rsp_data", RSP_DATA, 0);
        chk("midframe_rst_pulses", {RSP_VLD, RSP_TIMEOUT, CMD_DONE}, 0);
        tx_q.delete();
        out_q.delete();
        last_rsp = 8'h00;
        tick();
        tick();
        RST = 1'b1;
        tick();
        run_cmd(2'b00, 4'h7, 8'hC3, 8'h00, 8'h00, 4'h0, 0, 8'h00, 0, 1'b0);
        run_cmd(2'b01, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0, 1, 8'h42, 0, 1'b0);

        repeat (4) tick();
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("outcome_queue_drained", out_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
